// File: rtl/ddp_packet_sink_pkg.sv
// Shared constants and FSM state type for the DDP ring packet sink.
package ddp_packet_sink_pkg;

  localparam int unsigned DDP_PACKET_SIZE = 38;

  typedef enum logic {
    StIdle  = 1'b0,
    StAcked = 1'b1
  } sink_state_e;

endpackage

// File: rtl/ddp_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered head word that holds
// its last value once the FIFO drains.
module ddp_sync_fifo
  import ddp_packet_sink_pkg::*;
#(
  parameter int unsigned PKT_W = DDP_PACKET_SIZE,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   MR,
  input  logic                   wr_en,
  input  logic [PKT_W-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [PKT_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullLvl = (AW+1)'(DEPTH);
  localparam logic [AW:0] OneLvl  = (AW+1)'(1);

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [AW:0]      level_q;
  logic [PKT_W-1:0] head_q;
  logic             do_wr, do_rd;

  assign full       = (level_q == FullLvl);
  assign empty      = (level_q == '0);
  assign do_wr      = wr_en && !full;
  assign do_rd      = rd_en && !empty;
  assign rd_ptr_nxt = rd_ptr_q + 1'b1;
  assign level      = level_q;
  assign rd_data    = head_q;

  always_ff @(posedge CLK) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_nxt;
      level_q <= level_q + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
      // Head tracks the next unread word; when the last word leaves it keeps that word.
      if (empty && do_wr) begin
        head_q <= wr_data;
      end else if (do_rd) begin
        if (level_q > OneLvl) begin
          head_q <= mem_q[rd_ptr_nxt];
        end else if (do_wr) begin
          head_q <= wr_data;
        end
      end
    end
  end

endmodule

// File: rtl/ddp_packet_sink.sv
// Clocked receiver for the DDP ring's 4-phase Send/Ack/PACKET channel: synchronises
// Send_in, captures bundled packets into a FIFO and presents them via valid/ready.
module ddp_packet_sink
  import ddp_packet_sink_pkg::*;
#(
  parameter int unsigned PKT_W = DDP_PACKET_SIZE,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   MR,
  input  logic                   Send_in,
  input  logic [PKT_W-1:0]       PACKET_IN,
  output logic                   Ack_out,
  output logic                   pkt_valid,
  output logic [PKT_W-1:0]       pkt_data,
  input  logic                   pkt_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       rx_count
);

  logic        send_meta_q, send_s_q;
  sink_state_e state_q, state_d;
  logic        fifo_wr, fifo_full, fifo_empty;
  logic [CNT_W-1:0] rx_count_q;

  // Send_in is asynchronous; PACKET_IN is bundled and stable while it is high.
  always_ff @(posedge CLK) begin
    if (MR) begin
      send_meta_q <= 1'b0;
      send_s_q    <= 1'b0;
    end else begin
      send_meta_q <= Send_in;
      send_s_q    <= send_meta_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (send_s_q && !fifo_full) state_d = StAcked;
      StAcked: if (!send_s_q) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Ack_out comes straight from the state flop, so it is glitch-free toward upstream.
  always_comb begin
    Ack_out = (state_q == StAcked);
    fifo_wr = (state_q == StIdle) && send_s_q && !fifo_full;
  end

  always_ff @(posedge CLK) begin
    if (MR) begin
      rx_count_q <= '0;
    end else if (fifo_wr) begin
      rx_count_q <= rx_count_q + 1'b1;
    end
  end

  assign rx_count  = rx_count_q;
  assign pkt_valid = !fifo_empty;

  ddp_sync_fifo #(
    .PKT_W (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .MR      (MR),
    .wr_en   (fifo_wr),
    .wr_data (PACKET_IN),
    .rd_en   (pkt_ready),
    .rd_data (pkt_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_ddp_packet_sink.sv
// Bench for ddp_packet_sink: per-cycle comparison against a queue-based model of the
// handshake/FIFO rules, plus directed literal checks.
module tb_ddp_packet_sink;

  localparam int unsigned PKT_W = 38;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;

  logic             CLK = 1'b0;
  logic             MR = 1'b1;
  logic             Send_in = 1'b0;
  logic [PKT_W-1:0] PACKET_IN = '0;
  logic             pkt_ready = 1'b0;
  logic             Ack_out;
  logic             pkt_valid;
  logic [PKT_W-1:0] pkt_data;
  logic [2:0]       fifo_level;
  logic [CNT_W-1:0] rx_count;

  always #5 CLK = ~CLK;

  ddp_packet_sink #(
    .PKT_W (PKT_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .CLK        (CLK),
    .MR         (MR),
    .Send_in    (Send_in),
    .PACKET_IN  (PACKET_IN),
    .Ack_out    (Ack_out),
    .pkt_valid  (pkt_valid),
    .pkt_data   (pkt_data),
    .pkt_ready  (pkt_ready),
    .fifo_level (fifo_level),
    .rx_count   (rx_count)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: Send_in seen through two sample stages; handshake and FIFO as plain queue ops.
  bit               m_s1, m_s2, m_ack, m_live, m_wr, m_nack;
  logic [PKT_W-1:0] m_q[$];
  logic [PKT_W-1:0] m_last;
  logic [CNT_W-1:0] m_cnt;

  always @(negedge CLK) begin
    if (m_live) begin
      check("ack", 64'(Ack_out), 64'(m_ack));
      check("valid", 64'(pkt_valid), 64'(m_q.size() != 0));
      check("data", 64'(pkt_data), 64'((m_q.size() != 0) ? m_q[0] : m_last));
      check("level", 64'(fifo_level), 64'(m_q.size()));
      check("rx_count", 64'(rx_count), 64'(m_cnt));
    end
    // Inputs now are what the next rising edge samples.
    if (MR) begin
      m_s1 = 0; m_s2 = 0; m_ack = 0; m_last = '0; m_cnt = '0;
      m_q.delete();
      m_live = 1;
    end else begin
      m_wr   = !m_ack && m_s2 && (m_q.size() < DEPTH);
      m_nack = m_ack ? m_s2 : m_wr;
      if (pkt_ready && m_q.size() > 0) m_last = m_q.pop_front();
      if (m_wr) begin
        m_q.push_back(PACKET_IN);
        m_cnt++;
      end
      m_ack = m_nack;
      m_s2  = m_s1;
      m_s1  = Send_in;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input string name);
    int i;
    i = 0;
    while (Ack_out !== lvl && i < 20) begin
      tick(1);
      i++;
    end
    if (Ack_out !== lvl) check(name, 64'(Ack_out), 64'(lvl));
  endtask

  task automatic send_pkt(input logic [PKT_W-1:0] d);
    PACKET_IN = d;
    Send_in   = 1'b1;
    wait_ack(1'b1, "ack_rise_timeout");
    Send_in = 1'b0;
    wait_ack(1'b0, "ack_fall_timeout");
  endtask

  logic [PKT_W-1:0] pk [6];

  initial begin
    pk[0] = 38'h2A_1234_5678;
    pk[1] = 38'h01_0000_0001;
    pk[2] = 38'h3F_FFFF_FFFF;
    pk[3] = 38'h15_5555_AAAA;
    pk[4] = 38'h0C_AFE0_BEEF;
    pk[5] = 38'h20_0000_0000;

    MR = 1'b1;
    tick(2);
    MR = 1'b0;
    check("rst_ack", 64'(Ack_out), 64'd0);
    check("rst_valid", 64'(pkt_valid), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_count", 64'(rx_count), 64'd0);
    check("rst_data", 64'(pkt_data), 64'd0);

    // Single packet: capture two edges after first sample.
    PACKET_IN = pk[0];
    Send_in   = 1'b1;
    tick(2);
    check("t1_ack_early", 64'(Ack_out), 64'd0);
    tick(1);
    check("t1_ack", 64'(Ack_out), 64'd1);
    check("t1_valid", 64'(pkt_valid), 64'd1);
    check("t1_data", 64'(pkt_data), 64'(38'h2A_1234_5678));
    check("t1_count", 64'(rx_count), 64'd1);
    Send_in = 1'b0;
    tick(2);
    check("t1_ack_hold", 64'(Ack_out), 64'd1);
    tick(1);
    check("t1_ack_fall", 64'(Ack_out), 64'd0);
    pkt_ready = 1'b1;
    tick(1);
    pkt_ready = 1'b0;
    check("t1_drained", 64'(fifo_level), 64'd0);
    check("t1_data_hold", 64'(pkt_data), 64'(38'h2A_1234_5678));

    // Back-pressure: four fill the FIFO, fifth stalls until a pop.
    for (int i = 1; i <= 4; i++) send_pkt(pk[i]);
    check("t2_full_level", 64'(fifo_level), 64'd4);
    PACKET_IN = pk[5];
    Send_in   = 1'b1;
    tick(6);
    check("t2_stall_ack", 64'(Ack_out), 64'd0);
    pkt_ready = 1'b1;
    tick(1);
    pkt_ready = 1'b0;
    check("t2_pop_full_level", 64'(fifo_level), 64'd3);
    check("t2_pop_full_ack", 64'(Ack_out), 64'd0);
    tick(1);
    check("t2_cap5_ack", 64'(Ack_out), 64'd1);
    check("t2_cap5_level", 64'(fifo_level), 64'd4);
    Send_in = 1'b0;
    wait_ack(1'b0, "t2_ack_fall_timeout");
    for (int i = 2; i <= 5; i++) begin
      check("t2_order", 64'(pkt_data), 64'(pk[i]));
      pkt_ready = 1'b1;
      tick(1);
      pkt_ready = 1'b0;
    end
    check("t2_empty", 64'(pkt_valid), 64'd0);

    // Simultaneous pop and write at level 2.
    send_pkt(pk[0]);
    send_pkt(pk[1]);
    check("t3_level_pre", 64'(fifo_level), 64'd2);
    PACKET_IN = pk[2];
    Send_in   = 1'b1;
    tick(2);
    pkt_ready = 1'b1;
    tick(1);
    pkt_ready = 1'b0;
    check("t3_level", 64'(fifo_level), 64'd2);
    check("t3_head", 64'(pkt_data), 64'(pk[1]));
    check("t3_ack", 64'(Ack_out), 64'd1);
    Send_in = 1'b0;
    wait_ack(1'b0, "t3_ack_fall_timeout");
    pkt_ready = 1'b1;
    tick(2);
    pkt_ready = 1'b0;
    check("t3_drained", 64'(fifo_level), 64'd0);

    // Reset while acked with Send_in still high: packet is captured again.
    PACKET_IN = pk[3];
    Send_in   = 1'b1;
    wait_ack(1'b1, "t4_ack_timeout");
    MR = 1'b1;
    tick(1);
    MR = 1'b0;
    check("t4_rst_ack", 64'(Ack_out), 64'd0);
    check("t4_rst_valid", 64'(pkt_valid), 64'd0);
    check("t4_rst_level", 64'(fifo_level), 64'd0);
    check("t4_rst_count", 64'(rx_count), 64'd0);
    check("t4_rst_data", 64'(pkt_data), 64'd0);
    tick(2);
    check("t4_ack_early", 64'(Ack_out), 64'd0);
    tick(1);
    check("t4_recap_ack", 64'(Ack_out), 64'd1);
    check("t4_recap_count", 64'(rx_count), 64'd1);
    check("t4_recap_data", 64'(pkt_data), 64'(pk[3]));
    Send_in = 1'b0;
    wait_ack(1'b0, "t4_ack_fall_timeout");
    pkt_ready = 1'b1;
    tick(1);
    pkt_ready = 1'b0;

    // Counter wrap: 17 packets into a 4-bit counter.
    MR = 1'b1;
    tick(1);
    MR = 1'b0;
    pkt_ready = 1'b1;
    for (int i = 0; i < 17; i++) send_pkt(PKT_W'(64'h1357_9BDF * (i + 1)));
    tick(2);
    check("t5_count_wrap", 64'(rx_count), 64'd1);
    check("t5_level", 64'(fifo_level), 64'd0);
    pkt_ready = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
